// File: rtl/axi_write_master.sv
// Single-outstanding AXI write master: buffers store requests in a small FIFO
// and issues each one as an AW/W pair, then waits for the B response.
module axi_write_master #(
  parameter int unsigned DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_data,
  output logic        awvalid,
  output logic [31:0] awaddr,
  input  logic        awready,
  output logic        wvalid,
  output logic [31:0] wdata,
  input  logic        wready,
  input  logic        bvalid,
  input  logic [1:0]  bresp,
  output logic        bready,
  output logic        done,
  output logic        done_err,
  output logic        busy,
  output logic [7:0]  err_cnt
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [31:0]        mem_addr_q [0:DEPTH-1];
  logic [31:0]        mem_data_q [0:DEPTH-1];
  logic               awvalid_q, awvalid_d;
  logic               wvalid_q, wvalid_d;
  logic [31:0]        awaddr_q, awaddr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic               aw_done_q, aw_done_d;
  logic               w_done_q, w_done_d;
  logic               bready_q, bready_d;
  logic               done_q, done_d;
  logic               done_err_q, done_err_d;
  logic [7:0]         err_cnt_q, err_cnt_d;
  logic               req_ready_q, req_ready_d;
  logic               busy_q, busy_d;
  logic               push, pop, b_hs;

  // FIFO pointer and occupancy update; a pop only happens from IDLE
  always_comb begin
    push     = req_valid & req_ready_q;
    pop      = (state_q == IDLE) && (count_q != '0);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // FIFO storage; contents need no reset since occupancy gates every read
  always_ff @(posedge clk) begin
    if (push) begin
      mem_addr_q[wr_ptr_q] <= req_addr;
      mem_data_q[wr_ptr_q] <= req_data;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count_q != '0) state_d = SEND;
      SEND:    if (aw_done_q && w_done_q) state_d = RESP;
      RESP:    if (bvalid && bready_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output and channel-tracking logic; every output is registered
  always_comb begin
    awvalid_d  = awvalid_q;
    wvalid_d   = wvalid_q;
    awaddr_d   = awaddr_q;
    wdata_d    = wdata_q;
    aw_done_d  = aw_done_q;
    w_done_d   = w_done_q;
    bready_d   = bready_q;
    err_cnt_d  = err_cnt_q;
    done_d     = 1'b0;
    done_err_d = 1'b0;
    b_hs       = bvalid & bready_q;
    case (state_q)
      IDLE: begin
        if (pop) begin
          awaddr_d  = mem_addr_q[rd_ptr_q];
          wdata_d   = mem_data_q[rd_ptr_q];
          awvalid_d = 1'b1;
          wvalid_d  = 1'b1;
          aw_done_d = 1'b0;
          w_done_d  = 1'b0;
        end
      end
      SEND: begin
        if (awvalid_q && awready) begin
          awvalid_d = 1'b0;
          aw_done_d = 1'b1;
        end
        if (wvalid_q && wready) begin
          wvalid_d = 1'b0;
          w_done_d = 1'b1;
        end
        if (aw_done_q && w_done_q) bready_d = 1'b1;
      end
      RESP: begin
        if (b_hs) begin
          bready_d   = 1'b0;
          done_d     = 1'b1;
          done_err_d = (bresp != 2'b00);
          if ((bresp != 2'b00) && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
        end
      end
      default: begin
        awvalid_d = 1'b0;
        wvalid_d  = 1'b0;
        bready_d  = 1'b0;
      end
    endcase
    req_ready_d = (count_d != CNT_W'(DEPTH));
    busy_d      = (count_d != '0) || (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      awvalid_q   <= 1'b0;
      wvalid_q    <= 1'b0;
      awaddr_q    <= '0;
      wdata_q     <= '0;
      aw_done_q   <= 1'b0;
      w_done_q    <= 1'b0;
      bready_q    <= 1'b0;
      done_q      <= 1'b0;
      done_err_q  <= 1'b0;
      err_cnt_q   <= '0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      awvalid_q   <= awvalid_d;
      wvalid_q    <= wvalid_d;
      awaddr_q    <= awaddr_d;
      wdata_q     <= wdata_d;
      aw_done_q   <= aw_done_d;
      w_done_q    <= w_done_d;
      bready_q    <= bready_d;
      done_q      <= done_d;
      done_err_q  <= done_err_d;
      err_cnt_q   <= err_cnt_d;
      req_ready_q <= req_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign req_ready = req_ready_q;
  assign awvalid   = awvalid_q;
  assign awaddr    = awaddr_q;
  assign wvalid    = wvalid_q;
  assign wdata     = wdata_q;
  assign bready    = bready_q;
  assign done      = done_q;
  assign done_err  = done_err_q;
  assign busy      = busy_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_axi_write_master.sv
// Bench for axi_write_master: scripted responder, queue-based store model,
// and a protocol monitor that tallies handshake/stability/pulse violations.
`timescale 1ns/1ps
module tb_axi_write_master;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [31:0] req_addr = '0;
  logic [31:0] req_data = '0;
  logic        awvalid;
  logic [31:0] awaddr;
  logic        awready = 1'b0;
  logic        wvalid;
  logic [31:0] wdata;
  logic        wready = 1'b0;
  logic        bvalid = 1'b0;
  logic [1:0]  bresp = 2'b00;
  logic        bready;
  logic        done;
  logic        done_err;
  logic        busy;
  logic [7:0]  err_cnt;

  axi_write_master #(.DEPTH(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_data(req_data),
    .awvalid(awvalid), .awaddr(awaddr), .awready(awready),
    .wvalid(wvalid), .wdata(wdata), .wready(wready),
    .bvalid(bvalid), .bresp(bresp), .bready(bready),
    .done(done), .done_err(done_err), .busy(busy), .err_cnt(err_cnt)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  // Reference model: accepted stores in push order, and saturating error total
  logic [63:0] exp_q[$];
  int          exp_err = 0;

  // Protocol monitor, sampled just after each rising edge
  int          cyc = 0, viol = 0, done_cnt = 0, done_err_cnt = 0;
  int          last_aw_rise = 0, aw_interval = 0;
  logic        p_aw = 1'b0, p_w = 1'b0, p_done = 1'b0, p_rst = 1'b0;
  logic [31:0] p_addr = '0, p_data = '0;

  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst_n && p_rst) begin
      if (p_aw && !awready && !awvalid) viol++;
      if (p_aw && awready && awvalid)   viol++;
      if (p_w && !wready && !wvalid)    viol++;
      if (p_w && wready && wvalid)      viol++;
      if ((p_aw || p_w) && (awvalid || wvalid) && (awaddr !== p_addr || wdata !== p_data)) viol++;
      if (done && p_done)   viol++;
      if (done_err && !done) viol++;
      if (done) begin
        done_cnt++;
        if (done_err) done_err_cnt++;
      end
      if (awvalid && !p_aw) begin
        aw_interval  = cyc - last_aw_rise;
        last_aw_rise = cyc;
      end
    end
    p_rst  = rst_n;
    p_aw   = awvalid;
    p_w    = wvalid;
    p_done = done;
    p_addr = awaddr;
    p_data = wdata;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  // Offer one request and wait (bounded) for it to be accepted
  task automatic push_req(input logic [31:0] a, input logic [31:0] d);
    bit acc = 1'b0;
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    for (int n = 0; n < 400 && !acc; n++) begin
      if (req_ready) begin
        acc = 1'b1;
        exp_q.push_back({a, d});
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (!acc) begin
      errors++;
      $display("FAIL push_accept: accepted=%0d required=1", acc);
    end
  endtask

  // Responder for one store: delays counted from first sight of a valid
  task automatic serve_one(input int aw_dly, input int w_dly, input int b_dly,
                           input logic [1:0] resp, input bit early_b);
    bit started = 1'b0, aw_hs = 1'b0, w_hs = 1'b0, b_hs = 1'b0;
    bit aw_p = 1'b0, w_p = 1'b0, b_p = 1'b0;
    int t = 0, bt = 0, n = 0, bad_br = 0;
    logic [31:0] cap_a = '0, cap_d = '0;
    logic [63:0] expd;
    while (!b_hs && n < 300) begin
      if (awvalid || wvalid) started = 1'b1;
      awready = started && !aw_hs && awvalid && (t >= aw_dly);
      wready  = started && !w_hs && wvalid && (t >= w_dly);
      bvalid  = (early_b && started) || (aw_hs && w_hs && (bt >= b_dly));
      bresp   = bvalid ? resp : 2'b00;
      if (awready) begin aw_p = 1'b1; cap_a = awaddr; end
      if (wready)  begin w_p = 1'b1;  cap_d = wdata;  end
      if (bvalid && bready) b_p = 1'b1;
      if (bready && !(aw_hs && w_hs)) bad_br++;
      @(negedge clk);
      n++;
      if (started) t++;
      if (aw_hs && w_hs) bt++;
      if (aw_p) aw_hs = 1'b1;
      if (w_p)  w_hs = 1'b1;
      if (b_p)  b_hs = 1'b1;
      aw_p = 1'b0; w_p = 1'b0; b_p = 1'b0;
    end
    awready = 1'b0;
    wready  = 1'b0;
    bvalid  = 1'b0;
    bresp   = 2'b00;
    checks++;
    if (!b_hs) begin
      errors++;
      $display("FAIL serve_complete: response_accepted=%0d required=1", b_hs);
    end
    checks++;
    if (bad_br != 0) begin
      errors++;
      $display("FAIL bready_before_resp: early_cycles=%0d required=0", bad_br);
    end
    checks++;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL store_payload: got addr=%h data=%h required=no store", cap_a, cap_d);
    end else begin
      expd = exp_q.pop_front();
      if ({cap_a, cap_d} !== expd) begin
        errors++;
        $display("FAIL store_payload: got addr=%h data=%h required addr=%h data=%h",
                 cap_a, cap_d, expd[63:32], expd[31:0]);
      end
    end
    if (b_hs && resp != 2'b00) exp_err = (exp_err >= 255) ? 255 : exp_err + 1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0) begin
      errors++;
      $display("FAIL reset_valids: aw=%b w=%b b=%b required 0 0 0", awvalid, wvalid, bready);
    end
    checks++;
    if (done !== 1'b0 || done_err !== 1'b0 || err_cnt !== 8'd0) begin
      errors++;
      $display("FAIL reset_status: done=%b done_err=%b err_cnt=%0d required 0 0 0", done, done_err, err_cnt);
    end
    checks++;
    if (awaddr !== 32'd0 || wdata !== 32'd0) begin
      errors++;
      $display("FAIL reset_payload: awaddr=%h wdata=%h required 0 0", awaddr, wdata);
    end
    checks++;
    if (req_ready !== 1'b1 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_fifo: req_ready=%b busy=%b required 1 0", req_ready, busy);
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (busy !== 1'b0 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL idle_after_reset: busy=%b awvalid=%b required 0 0", busy, awvalid);
    end
  endtask

  task automatic test_single_store;
    int d0 = done_cnt, e0 = done_err_cnt, v0 = viol;
    push_req(32'hA000_03F8, 32'h0000_0041);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL single_busy: busy=%b required 1", busy);
    end
    serve_one(1, 2, 0, 2'b00, 1'b0);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || done_err_cnt - e0 != 0) begin
      errors++;
      $display("FAIL single_done: done=%0d err=%0d required 1 0", done_cnt - d0, done_err_cnt - e0);
    end
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL single_idle: busy=%b required 0", busy);
    end
    checks++;
    if (viol != v0) begin
      errors++;
      $display("FAIL single_protocol: violations=%0d required 0", viol - v0);
    end
  endtask

  task automatic test_handshake_order;
    int aw_d[3] = '{0, 3, 1};
    int w_d[3]  = '{3, 0, 1};
    int d0 = done_cnt, v0 = viol;
    for (int i = 0; i < 3; i++) begin
      push_req($urandom, $urandom);
      serve_one(aw_d[i], w_d[i], 1, 2'b00, 1'b0);
    end
    checks++;
    if (done_cnt - d0 != 3) begin
      errors++;
      $display("FAIL order_done: done=%0d required 3", done_cnt - d0);
    end
    checks++;
    if (viol != v0) begin
      errors++;
      $display("FAIL order_protocol: violations=%0d required 0", viol - v0);
    end
  endtask

  task automatic test_fifo_full;
    int d0 = done_cnt;
    for (int i = 0; i < 3; i++) push_req($urandom, $urandom);
    checks++;
    if (req_ready !== 1'b0 || busy !== 1'b1) begin
      errors++;
      $display("FAIL fifo_full: req_ready=%b busy=%b required 0 1", req_ready, busy);
    end
    for (int i = 0; i < 3; i++) serve_one(0, 0, 0, 2'b00, 1'b0);
    checks++;
    if (aw_interval != 4) begin
      errors++;
      $display("FAIL back_to_back_interval: cycles=%0d required 4", aw_interval);
    end
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 3 || busy !== 1'b0 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL fifo_drain: done=%0d busy=%b left=%0d required 3 0 0", done_cnt - d0, busy, exp_q.size());
    end
  endtask

  task automatic test_error_resp;
    int e0 = done_err_cnt;
    logic [1:0] r;
    for (int i = 0; i < 2; i++) begin
      push_req($urandom, $urandom);
      serve_one(1, 0, 1, 2'b10, 1'b0);
    end
    checks++;
    if (done_err_cnt - e0 != 2) begin
      errors++;
      $display("FAIL err_done: done_err pulses=%0d required 2", done_err_cnt - e0);
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL err_count: err_cnt=%0d required %0d", err_cnt, exp_err);
    end
    for (int i = 0; i < 300 && exp_err < 255; i++) begin
      r = 2'($urandom_range(1, 3));
      push_req($urandom, $urandom);
      serve_one(0, 0, 0, r, 1'b0);
    end
    checks++;
    if (err_cnt !== 8'hFF) begin
      errors++;
      $display("FAIL err_reach_max: err_cnt=%0d required 255", err_cnt);
    end
    e0 = done_err_cnt;
    push_req($urandom, $urandom);
    serve_one(0, 0, 0, 2'b11, 1'b0);
    checks++;
    if (err_cnt !== 8'(exp_err) || done_err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL err_saturate: err_cnt=%0d done_err=%0d required %0d 1", err_cnt, done_err_cnt - e0, exp_err);
    end
  endtask

  task automatic test_reset_mid;
    int d0 = done_cnt;
    push_req($urandom, $urandom);
    push_req($urandom, $urandom);
    checks++;
    if (awvalid !== 1'b1 || busy !== 1'b1) begin
      errors++;
      $display("FAIL mid_in_send: awvalid=%b busy=%b required 1 1", awvalid, busy);
    end
    #1 rst_n = 1'b0;
    #1;
    checks++;
    if (awvalid !== 1'b0 || wvalid !== 1'b0 || bready !== 1'b0 || done !== 1'b0 ||
        req_ready !== 1'b1 || busy !== 1'b0 || err_cnt !== 8'd0 || awaddr !== 32'd0) begin
      errors++;
      $display("FAIL mid_reset_values: aw=%b w=%b b=%b done=%b rr=%b busy=%b ec=%0d addr=%h required 0 0 0 0 1 0 0 0",
               awvalid, wvalid, bready, done, req_ready, busy, err_cnt, awaddr);
    end
    exp_q.delete();
    exp_err = 0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (done_cnt != d0 || busy !== 1'b0 || awvalid !== 1'b0) begin
      errors++;
      $display("FAIL mid_after_release: done=%0d busy=%b awvalid=%b required 0 0 0", done_cnt - d0, busy, awvalid);
    end
    push_req(32'h1234_5678, 32'hCAFE_F00D);
    serve_one(1, 1, 0, 2'b00, 1'b0);
    checks++;
    if (done_cnt - d0 != 1) begin
      errors++;
      $display("FAIL mid_recover: done=%0d required 1", done_cnt - d0);
    end
  endtask

  task automatic test_early_bvalid;
    int d0 = done_cnt, e0 = done_err_cnt;
    push_req($urandom, $urandom);
    serve_one(2, 1, 0, 2'b00, 1'b1);
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 1 || done_err_cnt != e0) begin
      errors++;
      $display("FAIL early_b_done: done=%0d err=%0d required 1 0", done_cnt - d0, done_err_cnt - e0);
    end
  endtask

  task automatic test_random;
    int d0 = done_cnt, v0 = viol;
    fork
      begin
        for (int i = 0; i < 24; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clk);
          push_req($urandom, $urandom);
        end
      end
      begin
        for (int i = 0; i < 24; i++) begin
          int a = int'($urandom_range(0, 3));
          int w = int'($urandom_range(0, 3));
          int b = int'($urandom_range(0, 2));
          logic [1:0] r = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
          bit e = 1'($urandom_range(0, 1));
          serve_one(a, w, b, r, e);
        end
      end
    join
    @(negedge clk);
    checks++;
    if (done_cnt - d0 != 24 || exp_q.size() != 0) begin
      errors++;
      $display("FAIL random_done: done=%0d left=%0d required 24 0", done_cnt - d0, exp_q.size());
    end
    checks++;
    if (err_cnt !== 8'(exp_err)) begin
      errors++;
      $display("FAIL random_err_cnt: err_cnt=%0d required %0d", err_cnt, exp_err);
    end
    checks++;
    if (viol != v0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL random_protocol: violations=%0d busy=%b required 0 0", viol - v0, busy);
    end
  endtask

  initial begin
    test_reset();
    test_single_store();
    test_handshake_order();
    test_fifo_full();
    test_error_resp();
    test_reset_mid();
    test_early_bvalid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
